// File: rtl/irq_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irq_arbiter: edge-detecting, maskable fixed-priority interrupt arbiter    |
// |              feeding the CP0 interrupt request with a req/ack handshake.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module irq_arbiter #(
  parameter int N_SRC   = 8,
  parameter int CAUSE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   irq_src,
  input  logic               mask_we,
  input  logic [N_SRC-1:0]   mask_wdata,
  output logic [N_SRC-1:0]   mask_q,
  output logic [N_SRC-1:0]   pending_q,
  output logic               ir_out,
  input  logic               ir_taken,
  input  logic               eret,
  output logic [CAUSE_W-1:0] cause,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e             state_q;
  logic [N_SRC-1:0]   irq_prev_q;
  logic               edge_en_q;
  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   pending_d;
  logic [CAUSE_W-1:0] win_idx;
  logic               take;

  // edge_en_q blanks the first cycle after reset so a line already high is
  // only absorbed into irq_prev_q, never reported as a fresh edge.
  assign rise     = irq_src & ~irq_prev_q & {N_SRC{edge_en_q}};
  assign eligible = pending_q & mask_q;
  assign take     = (state_q == ST_REQ) && ir_taken;

  generate
    for (genvar i = 0; i < N_SRC; i++) begin : g_pend
      assign pending_d[i] = rise[i] | (pending_q[i] & ~(take && (cause == CAUSE_W'(i))));
    end
  endgenerate

  always_comb begin
    win_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = CAUSE_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      irq_prev_q <= '0;
      edge_en_q  <= 1'b0;
      pending_q  <= '0;
      mask_q     <= '0;
      cause      <= '0;
      ir_out     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      irq_prev_q <= irq_src;
      edge_en_q  <= 1'b1;
      pending_q  <= pending_d;
      if (mask_we) mask_q <= mask_wdata;

      case (state_q)
        ST_IDLE: begin
          if (|eligible) begin
            cause   <= win_idx;
            state_q <= ST_REQ;
            ir_out  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_REQ: begin
          if (ir_taken) begin
            state_q <= ST_SERVICE;
            ir_out  <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (eret) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ir_out  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_irq_arbiter: directed bench with a cycle-level reference model.        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_irq_arbiter;

  localparam int N_SRC   = 8;
  localparam int CAUSE_W = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_SRC-1:0]   irq_src = '0;
  logic               mask_we = 1'b0;
  logic [N_SRC-1:0]   mask_wdata = '0;
  logic [N_SRC-1:0]   mask_q;
  logic [N_SRC-1:0]   pending_q;
  logic               ir_out;
  logic               ir_taken = 1'b0;
  logic               eret = 1'b0;
  logic [CAUSE_W-1:0] cause;
  logic               busy;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  irq_arbiter #(.N_SRC(N_SRC), .CAUSE_W(CAUSE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (irq_src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask_q     (mask_q),
    .pending_q  (pending_q),
    .ir_out     (ir_out),
    .ir_taken   (ir_taken),
    .eret       (eret),
    .cause      (cause),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = waiting, 1 = requesting CP0, 2 = in handler.
  int               m_phase = 0;
  int               m_cause = 0;
  logic [N_SRC-1:0] m_mask  = '0;
  logic [N_SRC-1:0] m_pend  = '0;
  logic [N_SRC-1:0] m_last  = '1;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_cause = 0;
      m_mask  = '0;
      m_pend  = '0;
      m_last  = '1;  // lines high out of reset must toggle before they count
    end else begin
      logic [N_SRC-1:0] edges, elig, nxt;
      edges = irq_src & ~m_last;
      nxt   = m_pend;
      if (m_phase == 1 && ir_taken) nxt[m_cause] = 1'b0;
      nxt = nxt | edges;
      elig = m_pend & m_mask;
      case (m_phase)
        0: if (elig != 0) begin
             for (int i = 0; i < N_SRC; i++) begin
               if (elig[i]) begin m_cause = i; break; end
             end
             m_phase = 1;
           end
        1: if (ir_taken) m_phase = 2;
        default: if (eret) m_phase = 0;
      endcase
      m_pend = nxt;
      m_last = irq_src;
      if (mask_we) m_mask = mask_wdata;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      total += 5;
      if (mask_q !== m_mask) begin
        bad++; $display("FAIL mdl_mask got=%h want=%h t=%0t", mask_q, m_mask, $time);
      end
      if (pending_q !== m_pend) begin
        bad++; $display("FAIL mdl_pending got=%h want=%h t=%0t", pending_q, m_pend, $time);
      end
      if (ir_out !== (m_phase == 1)) begin
        bad++; $display("FAIL mdl_ir_out got=%b want=%b t=%0t", ir_out, (m_phase == 1), $time);
      end
      if (busy !== (m_phase != 0)) begin
        bad++; $display("FAIL mdl_busy got=%b want=%b t=%0t", busy, (m_phase != 0), $time);
      end
      if (cause !== CAUSE_W'(m_cause)) begin
        bad++; $display("FAIL mdl_cause got=%0d want=%0d t=%0t", cause, m_cause, $time);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Advance one posedge and settle inputs safely after it.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic ack_and_return();
    ir_taken = 1'b1; tick(); ir_taken = 1'b0;
    eret = 1'b1;     tick(); eret = 1'b0;
  endtask

  initial begin
    tick(2);
    checking = 1'b1;
    chk("rst_mask",  32'(mask_q), 32'h00);
    chk("rst_pend",  32'(pending_q), 32'h00);
    chk("rst_irout", 32'(ir_out), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    rst = 1'b0;
    tick();

    // Single source, full mask
    mask_we = 1'b1; mask_wdata = 8'hFF; tick(); mask_we = 1'b0;
    chk("mask_ff", 32'(mask_q), 32'hFF);
    irq_src = 8'h04; tick();
    chk("t1_pend", 32'(pending_q), 32'h04);
    chk("t1_irout_early", 32'(ir_out), 32'h0);
    tick();
    chk("t1_irout", 32'(ir_out), 32'h1);
    chk("t1_cause", 32'(cause), 32'd2);
    chk("t1_busy",  32'(busy), 32'h1);
    irq_src = 8'h00;

    // Acknowledge then return
    ir_taken = 1'b1; tick(); ir_taken = 1'b0;
    chk("t2_pend",  32'(pending_q), 32'h00);
    chk("t2_irout", 32'(ir_out), 32'h0);
    chk("t2_busy",  32'(busy), 32'h1);
    eret = 1'b1; tick(); eret = 1'b0;
    chk("t2_busy_off", 32'(busy), 32'h0);
    tick(3);
    chk("t2_quiet", 32'(ir_out), 32'h0);

    // Simultaneous edges: lowest index wins, the other follows after a gap
    irq_src = 8'h22; tick(2);
    chk("t3_cause1", 32'(cause), 32'd1);
    ir_taken = 1'b1; tick(); ir_taken = 1'b0;
    chk("t3_pend", 32'(pending_q), 32'h20);
    eret = 1'b1; tick(); eret = 1'b0;
    chk("t3_gap_irout", 32'(ir_out), 32'h0);
    chk("t3_gap_cause", 32'(cause), 32'd1);
    tick();
    chk("t3_irout5", 32'(ir_out), 32'h1);
    chk("t3_cause5", 32'(cause), 32'd5);
    ack_and_return();
    irq_src = 8'h00; tick();

    // Masked source stays pending until enabled
    mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
    irq_src = 8'h08; tick();
    chk("t4_pend", 32'(pending_q), 32'h08);
    tick(2);
    chk("t4_masked", 32'(ir_out), 32'h0);
    mask_we = 1'b1; mask_wdata = 8'h08; tick(); mask_we = 1'b0;
    chk("t4_irout_wait", 32'(ir_out), 32'h0);
    tick();
    chk("t4_irout", 32'(ir_out), 32'h1);
    chk("t4_cause", 32'(cause), 32'd3);
    ack_and_return();
    irq_src = 8'h00;
    mask_we = 1'b1; mask_wdata = 8'hFF; tick(); mask_we = 1'b0;

    // New edge coinciding with ack is kept
    irq_src = 8'h10; tick(2);
    chk("t5_cause4", 32'(cause), 32'd4);
    irq_src = 8'h00; tick();
    irq_src = 8'h10; ir_taken = 1'b1; tick(); ir_taken = 1'b0;
    chk("t5_pend_kept", 32'(pending_q), 32'h10);
    eret = 1'b1; tick(); eret = 1'b0;
    tick();
    chk("t5_rereq", 32'(ir_out), 32'h1);
    chk("t5_recause", 32'(cause), 32'd4);
    ir_taken = 1'b1; tick(); ir_taken = 1'b0;

    // Reset while servicing with sources held high
    irq_src = 8'h00; tick();
    irq_src = 8'h30; tick();
    chk("t6_pend30", 32'(pending_q), 32'h30);
    chk("t6_busy",   32'(busy), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_mask",  32'(mask_q), 32'h00);
    chk("t6_rst_pend",  32'(pending_q), 32'h00);
    chk("t6_rst_busy",  32'(busy), 32'h0);
    chk("t6_rst_cause", 32'(cause), 32'd0);
    mask_we = 1'b1; mask_wdata = 8'hFF; tick(); mask_we = 1'b0;
    tick(2);
    chk("t6_no_edge", 32'(pending_q), 32'h00);
    chk("t6_no_req",  32'(ir_out), 32'h0);
    irq_src = 8'h00; tick();
    irq_src = 8'h30; tick();
    chk("t6_retoggle", 32'(pending_q), 32'h30);
    tick();
    chk("t6_cause4", 32'(cause), 32'd4);
    chk("t6_irout",  32'(ir_out), 32'h1);
    tick(2);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
